// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen: parametrised PWM carrier/timebase with divider, shadowed period, min/max events and prescaled irq
//   clk, rst (async, active-high)
//   en, count_mode, mask_mode, clkdiv_en, clkdiv, period, init, carr_sel, sync_in, int_en, evt_prescale
//   carrier, dir, period_active, evt_min, evt_max, sync_out, irq
module pwm_carrier_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 4,
  parameter int EVT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       count_mode,
  input  logic [1:0]       mask_mode,
  input  logic             clkdiv_en,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] init,
  input  logic             carr_sel,
  input  logic             sync_in,
  input  logic             int_en,
  input  logic [EVT_W-1:0] evt_prescale,
  output logic [CNT_W-1:0] carrier,
  output logic             dir,
  output logic [CNT_W-1:0] period_active,
  output logic             evt_min,
  output logic             evt_max,
  output logic             sync_out,
  output logic             irq
);
  localparam logic [1:0] NO_COUNT = 2'd0;
  localparam logic [1:0] UP       = 2'd1;
  localparam logic [1:0] DOWN     = 2'd2;
  localparam logic [1:0] UPDOWN   = 2'd3;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] carrier_q, carrier_d, period_q, period_d, step_c;
  logic [DIV_W-1:0] div_q, div_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             dir_q, dir_d, step_dir, min_q, min_d, max_q, max_d, irq_q, irq_d;
  logic             tick, sync, adv, qual;

  // Next value if the carrier advances this cycle. In UPDOWN the direction
  // flips on the same edge the turning value (P or 0) appears.
  always_comb begin
    step_c   = carrier_q;
    step_dir = dir_q;
    case (count_mode)
      UP: begin
        step_c   = carrier_q >= period_q ? '0 : carrier_q + C_ONE;
        step_dir = 1'b0;
      end
      DOWN: begin
        step_c   = (carrier_q == '0 || carrier_q > period_q) ? period_q : carrier_q - C_ONE;
        step_dir = 1'b1;
      end
      UPDOWN: begin
        step_c   = !dir_q ? (carrier_q >= period_q ? period_q - C_ONE : carrier_q + C_ONE)
                          : (carrier_q == '0 ? C_ONE : carrier_q - C_ONE);
        step_dir = !dir_q ? (carrier_q >= period_q || step_c == period_q) : (carrier_q > C_ONE);
      end
      default: ;
    endcase
    if (period_q == '0) step_c = '0;
  end

  always_comb begin
    tick      = clkdiv_en ? (div_q == clkdiv) : 1'b1;
    sync      = !carr_sel && sync_in;
    adv       = en && !sync && tick && count_mode != NO_COUNT;
    min_d     = adv && step_c == '0;
    max_d     = adv && period_q != '0 && step_c == period_q;
    qual      = (mask_mode[0] && min_d) || (mask_mode[1] && max_d);
    carrier_d = !en ? (init < period ? init : period)
              : sync ? (init < period_q ? init : period_q)
              : adv ? step_c : carrier_q;
    dir_d     = (!en || sync) ? (count_mode == DOWN) : adv ? step_dir : dir_q;
    period_d  = (!en || mask_mode == 2'd0 || qual) ? period : period_q;
    div_d     = (!en || sync || tick) ? '0 : div_q + DIV_W'(1);
    evt_d     = !en ? '0 : qual ? (evt_q == evt_prescale ? '0 : evt_q + EVT_W'(1)) : evt_q;
    irq_d     = qual && evt_q == evt_prescale && int_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q <= '0;
      period_q  <= '0;
      div_q     <= '0;
      evt_q     <= '0;
      dir_q     <= 1'b0;
      min_q     <= 1'b0;
      max_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      carrier_q <= carrier_d;
      period_q  <= period_d;
      div_q     <= div_d;
      evt_q     <= evt_d;
      dir_q     <= dir_d;
      min_q     <= min_d;
      max_q     <= max_d;
      irq_q     <= irq_d;
    end
  end

  assign carrier       = carrier_q;
  assign dir           = dir_q;
  assign period_active = period_q;
  assign evt_min       = min_q;
  assign evt_max       = max_q;
  assign sync_out      = min_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_pwm_carrier_gen.sv
// tb_pwm_carrier_gen: directed bench for pwm_carrier_gen
module tb_pwm_carrier_gen;
  logic        clk = 1'b0, rst = 1'b0, en, clkdiv_en, carr_sel, sync_in, int_en;
  logic [1:0]  count_mode, mask_mode;
  logic [3:0]  clkdiv;
  logic [15:0] period, init;
  logic [2:0]  evt_prescale;
  logic [15:0] carrier, period_active;
  logic        dir, evt_min, evt_max, sync_out, irq;
  int n_chk = 0, n_fail = 0;

  int t1_c [6]  = '{1, 2, 3, 4, 0, 1};
  int t1_mx[6]  = '{0, 0, 0, 1, 0, 0};
  int t1_mn[6]  = '{0, 0, 0, 0, 1, 0};
  int t2_c [14] = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};
  int t2_d [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int t2_mx[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int t2_mn[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int t3_c [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
  int t3_p [8]  = '{4, 4, 4, 7, 7, 7, 7, 7};
  int t4_c [12] = '{1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0};
  int t4_i [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int t5_c [5]  = '{3, 2, 1, 0, 3};
  int t5_mx[5]  = '{1, 0, 0, 0, 1};
  int t5_mn[5]  = '{0, 0, 0, 1, 0};

  pwm_carrier_gen dut (
    .clk(clk), .rst(rst), .en(en), .count_mode(count_mode), .mask_mode(mask_mode),
    .clkdiv_en(clkdiv_en), .clkdiv(clkdiv), .period(period), .init(init),
    .carr_sel(carr_sel), .sync_in(sync_in), .int_en(int_en), .evt_prescale(evt_prescale),
    .carrier(carrier), .dir(dir), .period_active(period_active), .evt_min(evt_min),
    .evt_max(evt_max), .sync_out(sync_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setup(input logic [1:0] m, input logic [1:0] mk, input int p, input int ini,
                       input logic de, input logic [3:0] dv);
    en = 1'b0; count_mode = m; mask_mode = mk; period = 16'(p); init = 16'(ini);
    clkdiv_en = de; clkdiv = dv;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    en = 1'b0; count_mode = 2'd1; mask_mode = 2'd0; clkdiv_en = 1'b0; clkdiv = '0;
    period = 16'd4; init = '0; carr_sel = 1'b1; sync_in = 1'b0; int_en = 1'b0; evt_prescale = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_carrier", carrier, 0);
    check("rst_dir", dir, 0);
    check("rst_period", period_active, 0);
    check("rst_evt_min", evt_min, 0);
    check("rst_evt_max", evt_max, 0);
    check("rst_sync_out", sync_out, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;
    // UP, P=4, no divider
    setup(2'd1, 2'd0, 4, 0, 1'b0, 4'd0);
    check("up_start", carrier, 0);
    check("up_period", period_active, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("up_carrier", carrier, t1_c[i]);
      check("up_evt_max", evt_max, t1_mx[i]);
      check("up_evt_min", evt_min, t1_mn[i]);
      check("up_sync_out", sync_out, t1_mn[i]);
      check("up_dir", dir, 0);
    end
    // UPDOWN, P=3, divide by 2
    setup(2'd3, 2'd0, 3, 0, 1'b1, 4'd1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("ud_carrier", carrier, t2_c[i]);
      check("ud_dir", dir, t2_d[i]);
      check("ud_evt_max", evt_max, t2_mx[i]);
      check("ud_evt_min", evt_min, t2_mn[i]);
    end
    // UP, MAX mask, period request changes mid-cycle
    setup(2'd1, 2'd2, 4, 0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mask_carrier", carrier, t3_c[i]);
      check("mask_period", period_active, t3_p[i]);
      if (i == 0) period = 16'd7;
    end
    // UPDOWN, P=2, MINMAX, irq every 3rd event, then int_en=0
    int_en = 1'b1; evt_prescale = 3'd2;
    setup(2'd3, 2'd3, 2, 0, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("irq_carrier", carrier, t4_c[i]);
      check("irq_on", irq, t4_i[i]);
    end
    int_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("irq_off", irq, 0);
    end
    // DOWN, P=3
    setup(2'd2, 2'd0, 3, 0, 1'b0, 4'd0);
    check("dn_dir_load", dir, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dn_carrier", carrier, t5_c[i]);
      check("dn_evt_max", evt_max, t5_mx[i]);
      check("dn_evt_min", evt_min, t5_mn[i]);
      check("dn_dir", dir, 1);
    end
    // Master sync, then LOCAL ignores sync_in
    carr_sel = 1'b0;
    setup(2'd1, 2'd0, 10, 5, 1'b0, 4'd0);
    check("sync_init", carrier, 5);
    repeat (3) @(negedge clk);
    check("sync_pre", carrier, 8);
    sync_in = 1'b1;
    @(negedge clk);
    check("sync_carrier", carrier, 5);
    check("sync_evt_min", evt_min, 0);
    check("sync_evt_max", evt_max, 0);
    carr_sel = 1'b1;
    @(negedge clk);
    check("local_carrier", carrier, 6);
    @(negedge clk);
    check("local_carrier2", carrier, 7);
    sync_in = 1'b0;
    // Asynchronous reset between edges, then restart with P initially 0
    #2 rst = 1'b1;
    #1;
    check("arst_carrier", carrier, 0);
    check("arst_period", period_active, 0);
    check("arst_dir", dir, 0);
    check("arst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_c0", carrier, 0);
    check("restart_p0_min", evt_min, 1);
    check("restart_p0_max", evt_max, 0);
    check("restart_period", period_active, 10);
    @(negedge clk);
    check("restart_c1", carrier, 1);
    @(negedge clk);
    check("restart_c2", carrier, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
